// File: rtl/bcd_digit_accumulator.sv
// Accumulates a stream of decimal digits into a binary value with a valid/ready result hand-off.
// Optional macro BCD_DIGIT_CHECK_EN adds digit_err and rejects digit codes above 9.
module bcd_digit_accumulator #(
  parameter int MAX_DIGITS = 4,
  parameter int OUT_W      = 14,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             digit_ready,
  input  logic             clear,
  output logic [OUT_W-1:0] bin_value,
  output logic [CNT_W-1:0] bin_ndigits,
  output logic             bin_truncated,
  output logic             bin_valid,
`ifdef BCD_DIGIT_CHECK_EN
  output logic             digit_err,
`endif
  input  logic             bin_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_r, next_state_s;
  logic [OUT_W-1:0] acc_r, acc_next_s;
  logic [CNT_W-1:0] count_r, count_next_s, count_inc_s;
  logic             trunc_r, trunc_next_s;
  logic             digit_ready_r, digit_ready_next_s;
  logic             bin_valid_r, bin_valid_next_s;
  logic             accept_s, bad_digit_s, good_accept_s, terminate_s, release_s;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // clear wins over everything, so a digit offered alongside it is never taken
  assign accept_s      = digit_valid && digit_ready_r && !clear;
`ifdef BCD_DIGIT_CHECK_EN
  assign bad_digit_s   = accept_s && !is_bcd(digit);
`else
  assign bad_digit_s   = 1'b0;
`endif
  assign good_accept_s = accept_s && !bad_digit_s;
  assign count_inc_s   = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign terminate_s   = good_accept_s && (digit_last || (count_inc_s == CNT_W'(MAX_DIGITS)));
  assign release_s     = bin_valid_r && bin_ready;

  // State and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      digit_ready_r <= 1'b1;
      bin_valid_r   <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      digit_ready_r <= digit_ready_next_s;
      bin_valid_r   <= bin_valid_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    if (clear) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (terminate_s) begin
            next_state_s = HOLD;
          end else if (good_accept_s) begin
            next_state_s = ACCUM;
          end else begin
            next_state_s = state_r;
          end
        end
        HOLD: begin
          if (release_s) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = HOLD;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Handshake outputs follow the upcoming state so they are available as flops
  always_comb begin
    digit_ready_next_s = 1'b1;
    bin_valid_next_s   = 1'b0;
    case (next_state_s)
      HOLD: begin
        digit_ready_next_s = 1'b0;
        bin_valid_next_s   = 1'b1;
      end
      default: begin
        digit_ready_next_s = 1'b1;
        bin_valid_next_s   = 1'b0;
      end
    endcase
  end

  // Datapath: acc*10 + digit built from shifts, wrapping at OUT_W bits
  always_comb begin
    acc_next_s   = acc_r;
    count_next_s = count_r;
    trunc_next_s = trunc_r;
    if (clear || release_s) begin
      acc_next_s   = {OUT_W{1'b0}};
      count_next_s = {CNT_W{1'b0}};
      trunc_next_s = 1'b0;
    end else if (good_accept_s) begin
      acc_next_s   = (acc_r << 3) + (acc_r << 1) + OUT_W'(digit);
      count_next_s = count_inc_s;
      trunc_next_s = terminate_s && !digit_last;
    end else begin
      acc_next_s   = acc_r;
      count_next_s = count_r;
      trunc_next_s = trunc_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {OUT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      trunc_r <= 1'b0;
    end else begin
      acc_r   <= acc_next_s;
      count_r <= count_next_s;
      trunc_r <= trunc_next_s;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic digit_err_r;

  // One-cycle flag for an accepted non-decimal code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_err_r <= 1'b0;
    end else begin
      digit_err_r <= bad_digit_s;
    end
  end

  assign digit_err = digit_err_r;
`endif

  assign digit_ready   = digit_ready_r;
  assign bin_valid     = bin_valid_r;
  assign bin_value     = acc_r;
  assign bin_ndigits   = count_r;
  assign bin_truncated = trunc_r;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Directed bench for bcd_digit_accumulator with a result scoreboard.
// Build with BCD_DIGIT_CHECK_EN defined to exercise the digit_err variant.
module tb_bcd_digit_accumulator;

  localparam int MAXD = 4;
  localparam int OUTW = 14;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0]      digit = 4'd0;
  logic            digit_valid = 1'b0;
  logic            digit_last = 1'b0;
  logic            digit_ready;
  logic            clear = 1'b0;
  logic [OUTW-1:0] bin_value;
  logic [CNTW-1:0] bin_ndigits;
  logic            bin_truncated;
  logic            bin_valid;
  logic            bin_ready = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
  logic            digit_err;
`endif

  typedef struct {
    int   value;
    int   nd;
    logic trunc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_acc    = 0;
  int   m_cnt    = 0;

  bcd_digit_accumulator #(.MAX_DIGITS(MAXD), .OUT_W(OUTW), .CNT_W(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .digit_last   (digit_last),
    .digit_ready  (digit_ready),
    .clear        (clear),
    .bin_value    (bin_value),
    .bin_ndigits  (bin_ndigits),
    .bin_truncated(bin_truncated),
    .bin_valid    (bin_valid),
`ifdef BCD_DIGIT_CHECK_EN
    .digit_err    (digit_err),
`endif
    .bin_ready    (bin_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Offer one digit for one edge and advance the reference model
  task automatic send_digit(input logic [3:0] d, input logic last);
    bit bad;
    exp_t e;
    @(negedge clk);
    check("ready_before_digit", digit_ready, 1);
    digit = d; digit_last = last; digit_valid = 1'b1;
    @(posedge clk); #1;
    digit_valid = 1'b0; digit_last = 1'b0;
    bad = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    bad = (d > 4'd9);
    check("digit_err", digit_err, bad);
`endif
    if (!bad) begin
      m_acc = (m_acc * 10 + int'(d)) % (1 << OUTW);
      m_cnt++;
    end
    if (!bad && (last || m_cnt == MAXD)) begin
      e.value = m_acc; e.nd = m_cnt; e.trunc = !last;
      sb.push_back(e);
      model_reset();
      check("valid_latency", bin_valid, 1);
    end else begin
      check("running_value", bin_value, m_acc);
      check("running_ndigits", bin_ndigits, m_cnt);
      check("no_valid_mid_entry", bin_valid, 0);
    end
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, then release it
  task automatic collect();
    int n = 0;
    exp_t e;
    while (bin_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_timeout", bin_valid, 1);
    check("scoreboard_nonempty", sb.size() > 0, 1);
    if (bin_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check("bin_value", bin_value, e.value);
      check("bin_ndigits", bin_ndigits, e.nd);
      check("bin_truncated", bin_truncated, e.trunc);
    end
    bin_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", bin_valid, 0);
    check("idle_ready", digit_ready, 1);
    check("idle_value", bin_value, 0);
    check("idle_ndigits", bin_ndigits, 0);
    check("idle_trunc", bin_truncated, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; digit = 4'd8; digit_valid = 1'b1; digit_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; digit_valid = 1'b0; digit_last = 1'b0;
    model_reset();
    check("clear_value", bin_value, 0);
    check("clear_ndigits", bin_ndigits, 0);
    check("clear_valid", bin_valid, 0);
    check("clear_ready", digit_ready, 1);
  endtask

  initial begin
    // Reset asserted between edges: outputs must settle without a clock
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", digit_ready, 1);
    check("rst_valid", bin_valid, 0);
    check("rst_value", bin_value, 0);
    check("rst_ndigits", bin_ndigits, 0);
    check("rst_trunc", bin_truncated, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1,2,3 with last on 3; a lone digit_last without valid is ignored
    bin_ready = 1'b1;
    send_digit(4'd1, 1'b0);
    @(negedge clk); digit_last = 1'b1;
    @(posedge clk); #1; digit_last = 1'b0;
    check("last_without_valid", bin_valid, 0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b1);
    collect();

    // Four digits without last: truncated
    for (int i = 0; i < 4; i++) send_digit(4'd9, 1'b0);
    collect();

    // Held result with downstream stalled, digit offered while holding
    bin_ready = 1'b0;
    send_digit(4'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      digit = 4'd3; digit_valid = (i == 2);
      @(posedge clk); #1;
      digit_valid = 1'b0;
      check("hold_valid", bin_valid, 1);
      check("hold_value", bin_value, 7);
      check("hold_ready", digit_ready, 0);
    end
    collect();

    // Clear mid-entry, then a fresh single digit entry
    send_digit(4'd4, 1'b0);
    send_digit(4'd5, 1'b0);
    do_clear();
    send_digit(4'd6, 1'b1);
    collect();

    // Clear while a result is pending drops it
    bin_ready = 1'b0;
    send_digit(4'd1, 1'b1);
    do_clear();
    sb.delete();

    // Reset pulse during HOLD
    send_digit(4'd5, 1'b0);
    send_digit(4'd5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("hold_rst_valid", bin_valid, 0);
    check("hold_rst_ready", digit_ready, 1);
    check("hold_rst_value", bin_value, 0);
    check("hold_rst_ndigits", bin_ndigits, 0);
    check("hold_rst_trunc", bin_truncated, 0);
    sb.delete();
    model_reset();
    @(negedge clk); rst_n = 1'b1;

`ifdef BCD_DIGIT_CHECK_EN
    // Non-decimal code is consumed but leaves the entry untouched
    bin_ready = 1'b1;
    send_digit(4'd4, 1'b0);
    send_digit(4'hC, 1'b0);
    send_digit(4'd2, 1'b1);
    check("err_cleared", digit_err, 0);
    collect();
`else
    // Out-of-range codes feed the arithmetic; 15,15,15,15 wraps modulo 2^14
    bin_ready = 1'b1;
    send_digit(4'd4, 1'b0);
    send_digit(4'hC, 1'b0);
    send_digit(4'd2, 1'b1);
    collect();
    for (int i = 0; i < 4; i++) send_digit(4'hF, 1'b0);
    check("wrap_expected_281", sb.size() > 0 && sb[0].value == 281, 1);
    collect();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
